// File: rtl/irq_pending_latch.sv
// irq_pending_latch: captures request edges into a pending register, masks
// them and presents a frozen snapshot to the priority encoder until acked.
// Ports: clk, rst (sync, active-high); Req/Mask in; In/Enable/Valid out;
//        Ack/Ack_Idx in; Pending/Lost out; Lost_Clr in; Ack_Err out.
module irq_pending_latch (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Req,
  input  logic [7:0] Mask,
  output logic [7:0] In,
  output logic       Enable,
  output logic       Valid,
  input  logic       Ack,
  input  logic [2:0] Ack_Idx,
  output logic [7:0] Pending,
  output logic [7:0] Lost,
  input  logic       Lost_Clr,
  output logic       Ack_Err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_GAP
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] lost_q, lost_d;
  logic [7:0] in_q, in_d;
  logic       ack_err_q, ack_err_d;

  logic [7:0] req_rise;
  logic [7:0] ack_clr;
  logic       presenting;
  logic       ack_hit;
  logic       ack_bad;

  always_comb begin
    req_rise   = Req & ~prev_q;
    presenting = (state_q == S_PRESENT);
    ack_hit    = presenting && Ack && in_q[Ack_Idx];
    ack_bad    = presenting && Ack && !in_q[Ack_Idx];
    ack_clr    = ack_hit ? (8'h01 << Ack_Idx) : 8'h00;

    prev_d    = Req;
    // A new edge on a channel being acked re-arms it (set wins).
    pending_d = (pending_q & ~ack_clr) | req_rise;
    // Overflow only when the edge lands on a bit that stays pending.
    lost_d    = (Lost_Clr ? 8'h00 : lost_q)
              | (req_rise & pending_q & ~ack_clr);
    ack_err_d = ack_bad;
    state_d   = state_q;
    in_d      = in_q;

    unique case (state_q)
      S_IDLE: begin
        in_d = 8'h00;
        if ((pending_q & Mask) != 8'h00) begin
          state_d = S_PRESENT;
          in_d    = (pending_q | req_rise) & Mask;
        end
      end
      S_PRESENT: begin
        if (ack_hit) begin
          state_d = S_GAP;
          in_d    = 8'h00;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        in_d    = 8'h00;
      end
      default: begin
        state_d = S_IDLE;
        in_d    = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      prev_q    <= 8'hFF;
      pending_q <= 8'h00;
      lost_q    <= 8'h00;
      in_q      <= 8'h00;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      lost_q    <= lost_d;
      in_q      <= in_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign In      = in_q;
  assign Valid   = (state_q == S_PRESENT);
  assign Enable  = (state_q == S_PRESENT);
  assign Pending = pending_q;
  assign Lost    = lost_q;
  assign Ack_Err = ack_err_q;

endmodule
